fetch_queue: RTL

Instruction fetch queue between the fetch stage and decode in the out-of-order RISC-V front end. Fetch pushes groups of up to `MACHINE_WIDTH` instructions; decode pops up to `MACHINE_WIDTH` instructions per cycle in program order. The queue decouples fetch stalls from decode stalls and is cleared completely when retirement reports a branch misprediction.

---
 rtl/fetch_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch queue between fetch and decode. Fetch writes groups of up
//   to MACHINE_WIDTH instructions (lane-valid mask contiguous from lane 0) into a
//   circular buffer; decode sees up to MACHINE_WIDTH of the oldest entries each
//   cycle and, when dec_ready is high, consumes all of them at once. A flush
//   from retirement (branch misprediction) empties the queue.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               discard all entries; wins over enqueue/dequeue
//   fetch_valid         incoming lane-valid mask (contiguous from lane 0)
//   fetch_pc/inst/pred_taken  incoming per-lane payload
//   fetch_ready         room for a full group (from registered count only)
//   dec_valid           outgoing lane-valid mask, lane 0 = oldest
//   dec_pc/inst/pred_taken    head entries, zero on invalid lanes
//   dec_ready           decode takes every valid lane this cycle
//   count               current occupancy
module fetch_queue #(
    parameter int MACHINE_WIDTH = 4,
    parameter int XLEN          = 32,
    parameter int DEPTH         = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [MACHINE_WIDTH-1:0]            fetch_valid,
    input  logic [MACHINE_WIDTH-1:0][XLEN-1:0]  fetch_pc,
    input  logic [MACHINE_WIDTH-1:0][31:0]      fetch_inst,
    input  logic [MACHINE_WIDTH-1:0]            fetch_pred_taken,
    output logic                                fetch_ready,
    output logic [MACHINE_WIDTH-1:0]            dec_valid,
    output logic [MACHINE_WIDTH-1:0][XLEN-1:0]  dec_pc,
    output logic [MACHINE_WIDTH-1:0][31:0]      dec_inst,
    output logic [MACHINE_WIDTH-1:0]            dec_pred_taken,
    input  logic                                dec_ready,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(MACHINE_WIDTH + 1);

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] pc_d   [DEPTH];
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     inst_d [DEPTH];
    logic            pred_q [DEPTH];
    logic            pred_d [DEPTH];

    logic [LW-1:0]   n_fetch;
    logic [LW-1:0]   k_head;
    logic            enq_fire;
    logic            deq_fire;
    logic [MACHINE_WIDTH-1:0] fetch_valid_inc;

    // Lane count of the incoming group; the mask is contiguous so popcount
    // equals the index of the first clear lane.
    always_comb begin
        n_fetch = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            n_fetch = n_fetch + LW'(fetch_valid[i]);
        end
    end

    always_comb begin
        if (count_q >= CW'(MACHINE_WIDTH)) begin
            k_head = LW'(MACHINE_WIDTH);
        end else begin
            k_head = LW'(count_q);
        end
    end

    // Ready looks only at the registered count, so a dequeue in the same cycle
    // cannot open a path from dec_ready to fetch_ready.
    assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(MACHINE_WIDTH);
    assign enq_fire    = fetch_ready && (fetch_valid != '0);
    assign deq_fire    = dec_ready && (k_head != '0);
    assign count       = count_q;

    always_comb begin
        dec_valid      = '0;
        dec_pc         = '0;
        dec_inst       = '0;
        dec_pred_taken = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            if (LW'(i) < k_head) begin
                dec_valid[i]      = 1'b1;
                dec_pc[i]         = pc_q[head_q + PW'(i)];
                dec_inst[i]       = inst_q[head_q + PW'(i)];
                dec_pred_taken[i] = pred_q[head_q + PW'(i)];
            end
        end
    end

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        pred_d = pred_q;
        if (enq_fire && !flush) begin
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (fetch_valid[i]) begin
                    pc_d[tail_q + PW'(i)]   = fetch_pc[i];
                    inst_d[tail_q + PW'(i)] = fetch_inst[i];
                    pred_d[tail_q + PW'(i)] = fetch_pred_taken[i];
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq_fire) begin
                head_d = head_q + PW'(k_head);
            end
            if (enq_fire) begin
                tail_d = tail_q + PW'(n_fetch);
            end
            count_d = count_q + (enq_fire ? CW'(n_fetch) : '0)
                              - (deq_fire ? CW'(k_head) : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: nothing is visible until count covers it.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
        pred_q <= pred_d;
    end

    assign fetch_valid_inc = fetch_valid + MACHINE_WIDTH'(1);

    // A contiguous-from-lane-0 mask is of the form 0..01..1, so adding one
    // leaves no bit in common with the original.
    property p_fetch_mask_contiguous;
        @(posedge clk) disable iff (!rst_n)
            (fetch_valid & fetch_valid_inc) == '0;
    endproperty
    a_fetch_mask_contiguous: assert property (p_fetch_mask_contiguous);

    property p_count_in_range;
        @(posedge clk) disable iff (!rst_n)
            count_q <= CW'(DEPTH);
    endproperty
    a_count_in_range: assert property (p_count_in_range);

endmodule
